// File: rtl/instr_fetch_seq_pkg.sv
// Shared constants for the sequenced instruction fetch/decode block: default
// widths, reset PC, EXTEND prefix word, FSM encoding and field positions.
package instr_fetch_seq_pkg;

    localparam int OP_W_DEF   = 3;
    localparam int ADDR_W_DEF = 12;
    localparam int WORD_W_DEF = 15;
    localparam int PC_W_DEF   = 12;

    localparam logic [11:0] RESET_PC_DEF    = 12'o4000;
    localparam logic [14:0] EXTEND_WORD_DEF = 15'o00006;

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    // Field positions scale with the address width; the opcode sits directly above it.
    function automatic int op_lsb(input int addr_w);
        return addr_w;
    endfunction

    function automatic int qc_lsb(input int addr_w);
        return addr_w - 2;
    endfunction

    function automatic int periph_bit(input int addr_w);
        return addr_w - 3;
    endfunction

endpackage

// File: rtl/instr_fetch_seq_field_decode.sv
// Pure combinational split of the instruction register into its fields,
// keeping the legacy splitter layout with the widths parametrised.
module instr_field_decode
    import instr_fetch_seq_pkg::*;
#(
    parameter int OP_W   = OP_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic [WORD_W-1:0] ir,
    output logic [OP_W-1:0]   opcode,
    output logic [1:0]        qc,
    output logic              peripheral_c,
    output logic [ADDR_W-1:0] addr12,
    output logic [ADDR_W-3:0] addr10
);

    localparam int OP_LSB     = op_lsb(ADDR_W);
    localparam int QC_LSB     = qc_lsb(ADDR_W);
    localparam int PERIPH_BIT = periph_bit(ADDR_W);

    assign opcode       = ir[OP_LSB +: OP_W];
    assign qc           = ir[QC_LSB +: 2];
    assign peripheral_c = ir[PERIPH_BIT];
    assign addr12       = ir[ADDR_W-1:0];
    // addr10 deliberately includes the peripheral bit as its MSB.
    assign addr10       = ir[PERIPH_BIT:0];

endmodule

// File: rtl/instr_fetch_seq.sv
// Two-state fetch sequencer: owns the PC, fetches over req/ack, absorbs the
// EXTEND prefix and presents decoded instructions over valid/ready.
module instr_fetch_seq
    import instr_fetch_seq_pkg::*;
#(
    parameter int              OP_W        = OP_W_DEF,
    parameter int              ADDR_W      = ADDR_W_DEF,
    parameter int              WORD_W      = WORD_W_DEF,
    parameter int              PC_W        = PC_W_DEF,
    parameter logic [PC_W-1:0]   RESET_PC    = RESET_PC_DEF,
    parameter logic [WORD_W-1:0] EXTEND_WORD = EXTEND_WORD_DEF
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic [PC_W-1:0]   mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_data,
    input  logic              pc_load,
    input  logic [PC_W-1:0]   pc_load_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   opcode,
    output logic [1:0]        qc,
    output logic              peripheral_c,
    output logic [ADDR_W-1:0] addr12,
    output logic [ADDR_W-3:0] addr10,
    output logic              extracode,
    output logic [PC_W-1:0]   instr_pc
);

    logic [0:0]        state;
    logic [PC_W-1:0]   pc;
    logic [WORD_W-1:0] ir;
    logic              ext_pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_FETCH;
            pc          <= RESET_PC;
            ir          <= '0;
            instr_pc    <= '0;
            ext_pending <= 1'b0;
        end else if (pc_load) begin
            // Redirect wins: any coincident ack or handshake is discarded.
            state       <= ST_FETCH;
            pc          <= pc_load_value;
            ext_pending <= 1'b0;
        end else if (state == ST_FETCH) begin
            if (mem_ack) begin
                pc <= pc + PC_W'(1);
                // An extended instruction reports the address of its prefix.
                if (!ext_pending) begin
                    instr_pc <= pc;
                end
                if (mem_data == EXTEND_WORD) begin
                    ext_pending <= 1'b1;
                end else begin
                    ir    <= mem_data;
                    state <= ST_ISSUE;
                end
            end
        end else if (out_ready) begin
            ext_pending <= 1'b0;
            state       <= ST_FETCH;
        end
    end

    assign mem_req   = (state == ST_FETCH);
    assign mem_addr  = pc;
    assign out_valid = (state == ST_ISSUE);
    assign extracode = ext_pending;

    instr_field_decode #(
        .OP_W   (OP_W),
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_decode (
        .ir           (ir),
        .opcode       (opcode),
        .qc           (qc),
        .peripheral_c (peripheral_c),
        .addr12       (addr12),
        .addr10       (addr10)
    );

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Scoreboard bench for instr_fetch_seq: expected instructions are queued at
// fetch time and compared when the DUT hands them to the execute stage.
module tb_instr_fetch_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [14:0] mem_data = '0;
    logic        pc_load = 1'b0;
    logic [11:0] pc_load_value = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  opcode;
    logic [1:0]  qc;
    logic        peripheral_c;
    logic [11:0] addr12;
    logic [9:0]  addr10;
    logic        extracode;
    logic [11:0] instr_pc;

    typedef struct packed {
        logic [2:0]  op;
        logic [1:0]  qc;
        logic        per;
        logic [11:0] a12;
        logic [9:0]  a10;
        logic        ext;
        logic [11:0] ipc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic        m_ext = 1'b0;
    logic [11:0] m_ipc = '0;

    instr_fetch_seq dut (
        .clk           (clk),
        .reset         (reset),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_data      (mem_data),
        .pc_load       (pc_load),
        .pc_load_value (pc_load_value),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .opcode        (opcode),
        .qc            (qc),
        .peripheral_c  (peripheral_c),
        .addr12        (addr12),
        .addr10        (addr10),
        .extracode     (extracode),
        .instr_pc      (instr_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [14:0] w, input logic e, input logic [11:0] ipc);
        exp_t r;
        r.op  = w[14:12];
        r.qc  = w[11:10];
        r.per = w[9];
        r.a12 = w[11:0];
        r.a10 = w[9:0];
        r.ext = e;
        r.ipc = ipc;
        return r;
    endfunction

    function automatic exp_t fields_now();
        exp_t r;
        r.op  = opcode;
        r.qc  = qc;
        r.per = peripheral_c;
        r.a12 = addr12;
        r.a10 = addr10;
        r.ext = extracode;
        r.ipc = instr_pc;
        return r;
    endfunction

    task automatic wait_req();
        int n = 0;
        while (!mem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!mem_req) chk("req_timeout", 64'(0), 64'(1));
    endtask

    task automatic do_fetch(input logic [11:0] a, input logic [14:0] w);
        wait_req();
        chk("mem_addr", 64'(mem_addr), 64'(a));
        if (!m_ext) m_ipc = a;
        if (w == 15'o00006) begin
            m_ext = 1'b1;
        end else begin
            exp_q.push_back(mk(w, m_ext, m_ipc));
            m_ext = 1'b0;
        end
        mem_ack  = 1'b1;
        mem_data = w;
        @(negedge clk);
        mem_ack  = 1'b0;
        mem_data = '0;
        chk("fetch_latency_valid", 64'(out_valid), 64'(w != 15'o00006));
    endtask

    task automatic consume(input int hold);
        exp_t e;
        exp_t cur;
        exp_t first;
        int   n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("valid_timeout", 64'(0), 64'(1));
        first = fields_now();
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(out_valid), 64'(1));
            cur = fields_now();
            chk("hold_fields", 64'(cur), 64'(first));
        end
        if (exp_q.size() == 0) begin
            chk("sb_empty", 64'(0), 64'(1));
        end else begin
            e   = exp_q.pop_front();
            cur = fields_now();
            chk("opcode", 64'(cur.op), 64'(e.op));
            chk("qc", 64'(cur.qc), 64'(e.qc));
            chk("peripheral_c", 64'(cur.per), 64'(e.per));
            chk("addr12", 64'(cur.a12), 64'(e.a12));
            chk("addr10", 64'(cur.a10), 64'(e.a10));
            chk("extracode", 64'(cur.ext), 64'(e.ext));
            chk("instr_pc", 64'(cur.ipc), 64'(e.ipc));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_hs_valid", 64'(out_valid), 64'(0));
        chk("post_hs_req", 64'(mem_req), 64'(1));
    endtask

    initial begin
        // Test 1: reset state
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_mem_req", 64'(mem_req), 64'(1));
        chk("rst_mem_addr", 64'(mem_addr), 64'(12'o4000));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_opcode", 64'(opcode), 64'(0));
        chk("rst_qc", 64'(qc), 64'(0));
        chk("rst_periph", 64'(peripheral_c), 64'(0));
        chk("rst_addr12", 64'(addr12), 64'(0));
        chk("rst_addr10", 64'(addr10), 64'(0));
        chk("rst_extracode", 64'(extracode), 64'(0));
        chk("rst_instr_pc", 64'(instr_pc), 64'(0));

        // Test 2: zero-wait fetch with explicit field values
        do_fetch(12'o4000, 15'o65421);
        chk("t2_opcode", 64'(opcode), 64'(3'b110));
        chk("t2_qc", 64'(qc), 64'(2'b10));
        chk("t2_periph", 64'(peripheral_c), 64'(1));
        chk("t2_addr12", 64'(addr12), 64'(12'b101100010001));
        chk("t2_addr10", 64'(addr10), 64'(10'b1100010001));
        chk("t2_extracode", 64'(extracode), 64'(0));
        chk("t2_instr_pc", 64'(instr_pc), 64'(12'o4000));
        consume(0);
        chk("t2_next_addr", 64'(mem_addr), 64'(12'o4001));

        // Test 3: EXTEND prefix absorbed into extracode
        do_fetch(12'o4001, 15'o00006);
        do_fetch(12'o4002, 15'o30100);
        chk("t3_opcode", 64'(opcode), 64'(3'b011));
        chk("t3_extracode", 64'(extracode), 64'(1));
        chk("t3_instr_pc", 64'(instr_pc), 64'(12'o4001));
        consume(0);

        // Test 4: back-pressure holds outputs, next instruction not extended
        do_fetch(12'o4003, 15'o12345);
        consume(3);

        // Redirect while presenting: instruction dropped
        do_fetch(12'o4004, 15'o44444);
        pc_load       = 1'b1;
        pc_load_value = 12'o2000;
        out_ready     = 1'b1;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        @(negedge clk);
        pc_load   = 1'b0;
        out_ready = 1'b0;
        chk("issue_load_valid", 64'(out_valid), 64'(0));
        chk("issue_load_addr", 64'(mem_addr), 64'(12'o2000));

        // Test 5: redirect coincident with ack after an EXTEND
        do_fetch(12'o2000, 15'o00006);
        pc_load       = 1'b1;
        pc_load_value = 12'o1234;
        mem_ack       = 1'b1;
        mem_data      = 15'o54321;
        m_ext         = 1'b0;
        @(negedge clk);
        pc_load  = 1'b0;
        mem_ack  = 1'b0;
        mem_data = '0;
        chk("t5_valid", 64'(out_valid), 64'(0));
        chk("t5_addr", 64'(mem_addr), 64'(12'o1234));
        chk("t5_extracode", 64'(extracode), 64'(0));
        chk("t5_req", 64'(mem_req), 64'(1));
        do_fetch(12'o1234, 15'o22222);
        consume(0);

        // Test 6: PC wrap, then reset mid-FETCH
        pc_load       = 1'b1;
        pc_load_value = 12'o7777;
        @(negedge clk);
        pc_load = 1'b0;
        do_fetch(12'o7777, 15'o71234);
        consume(0);
        chk("t6_wrap_addr", 64'(mem_addr), 64'(12'o0000));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_rst_addr", 64'(mem_addr), 64'(12'o4000));
        chk("t6_rst_valid", 64'(out_valid), 64'(0));
        chk("t6_rst_req", 64'(mem_req), 64'(1));
        chk("t6_rst_ipc", 64'(instr_pc), 64'(0));
        do_fetch(12'o4000, 15'o10001);
        consume(0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
